pwm_breathe_multi: RTL and testbench
====================================

# pwm_breathe_multi

Multi-channel PWM generator with per-channel manual or breathing (triangle-ramp) duty control. It generalises the single-output LED PWM to `CHANNELS` outputs sharing one period counter, with a parametrised duty width, glitch-free duty updates at period boundaries, and a programmable breathing rate and ceiling. It sits between the top-level IO wrapper and the LED/output pads, and is configured through a simple write-strobe register port.

## Interface

**Parameters**
- `CHANNELS`, 4: number of PWM outputs (1–8).
- `DUTY_W`, 8: duty/counter width. PWM period is 2^DUTY_W−1 cycles.
- `STEP_W`, 16: width of the breathing step-period field.

**Ports**
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: global enable.
- `mode`, in, CHANNELS: per-channel mode; 1 = breathing, 0 = manual.
- `duty_wr`, in, 1: write strobe for a manual duty shadow register.
- `duty_sel`, in, $clog2(CHANNELS) (min 1): target channel of the write.
- `duty_data`, in, DUTY_W: manual duty value.
- `step_period`, in, STEP_W: N means one breathing step every N+1 PWM periods.
- `breath_max`, in, DUTY_W: breathing ceiling.
- `pwm_out`, out, CHANNELS: PWM outputs, registered.
- `period_tick`, out, 1: one-cycle pulse on the last cycle of each PWM period.

## Operation

- **Shared counter `cnt`:** counts 0..MAX, where MAX = 2^DUTY_W−2, and wraps to 0. It increments only when `en`=1, otherwise it holds. A wrap occurs in any cycle where `cnt`==MAX and `en`=1.
- **`period_tick`:** combinational, `cnt`==MAX && `en`.
- **Per-channel registers:**
  - `shadow[i]`: written when `duty_wr`=1 and `duty_sel`==i. Writes with `duty_sel`≥CHANNELS are ignored.
  - `active[i]`: loaded only at a wrap. It takes `shadow[i]` if `mode[i]`=0, or `level[i]` if `mode[i]`=1.
- **Output:** `pwm_out[i]` is registered as `en` && (`cnt` < `active[i]`). Duty 0 gives always low. Duty ≥ 2^DUTY_W−1 gives always high.
- **Breathing step counter `scnt`:**
  - Advances on each wrap.
  - When `scnt`==`step_period` at a wrap, it clears to 0 and a *step* fires.
- **Breathing channels (`mode[i]`=1)** on each step, using `level[i]` and direction `dir[i]`:
  - `dir`=up and `level` ≥ `breath_max`: `level` ← `breath_max`, `dir` ← down.
  - `dir`=up otherwise: `level` ← `level`+1.
  - `dir`=down and `level`==0: `dir` ← up, `level` stays 0.
  - `dir`=down otherwise: `level` ← `level`−1.
  - Result is a triangle wave with a one-step dwell at each end.
  - `breath_max`=0 holds `level` at 0.
  - Lowering `breath_max` below `level` clamps on the next up step. While `dir`=down, `level` decrements normally.
- **Manual channels (`mode[i]`=0):** `level[i]` ← 0 and `dir[i]` ← up every cycle, so breathing always restarts from 0.

## Timing

- **Reset (`rst`=1 at a clk edge):** `cnt`, `scnt`, all `shadow`, `active` and `level` ← 0; all `dir` ← up; `pwm_out` ← 0. `period_tick` is 0 while in reset. Reset overrides every other input, including mid-period and mid-breath.
- **Output latency:** `pwm_out` lags `cnt` by one cycle. The first cycle of a new period reflects the old duty; the new `active` value is visible from the second cycle of the period onward.
- **Duty write latency:** a write lands in `shadow` at the next edge. It reaches `active` at the first wrap strictly after that edge. A write in the same cycle as a wrap is deferred one period.
- **Step coincident with a wrap:** `active` loads the pre-step `level`, so a step becomes visible one period later.
- **Mode change:** takes effect at the next wrap.
- **`en`=0:** `cnt` and `scnt` freeze. `pwm_out` goes 0 one cycle later. `shadow` still accepts writes.

## Configuration

- **`PWM_BREATHE_EN` defined:** breathing logic is present as described above.
- **`PWM_BREATHE_EN` undefined:**
  - `scnt`, `level` and `dir` are removed.
  - `mode`, `step_period` and `breath_max` are ignored.
  - Every channel behaves as manual (`active` ← `shadow` at each wrap).
  - Port list is unchanged.

## Test plan

All scenarios use CHANNELS=4, DUTY_W=8, PWM_BREATHE_EN defined unless stated.

- **Reset/idle:** `rst` 1 for 3 cycles, then `en`=1 with no writes → `pwm_out`=0 for 600 cycles; `period_tick` pulses every 255 cycles, first pulse 255 cycles after `rst` falls.
- **Manual duty:** write ch0=64, ch1=0, ch2=255, ch3=128; check the second period → ch0 high exactly 64 of 255 cycles, ch1 never, ch2 always, ch3 128 cycles.
- **Shadow timing:** write ch0=200 in the `period_tick` cycle → the following period still shows the old duty; 200-cycle high starts one period later; no partial pulse lengths.
- **Breathing:** `mode`=4'b0001, `step_period`=0, `breath_max`=3 → successive periods of ch0 show duties 0,1,2,3,3,2,1,0,0,1… (accounting for the one-period `active` lag).
- **Clamp/abort:** breathing ch0 at `level`=10 rising, set `breath_max`=5 → next step `level`=5, then 4; assert `rst` mid-period → `pwm_out`=0 the next cycle; after release ch0 restarts from duty 0.
- **`en` gating and sel range:** `en`=0 for 50 cycles mid-period → `cnt` holds, outputs 0, and the period resumes where it left off; `duty_wr` with `duty_sel`=5 (CHANNELS=6 build) writes ch5, while `duty_sel`=7 changes nothing.

Source files
------------

// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi
//   Multi-channel PWM generator. All channels share one period counter. Each
//   channel either follows a manually written duty or a triangle "breathing"
//   ramp. Duty changes are applied only at period boundaries, so no output
//   ever shows a truncated or stretched pulse.
//
// Build option:
//   PWM_BREATHE_EN  defined   -> breathing ramp logic present
//                   undefined -> every channel is manual; mode, step_period
//                                and breath_max are accepted but ignored
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   en           in   global enable; freezes the counters and forces outputs low
//   mode         in   [CHANNELS]  per-channel: 1 = breathing, 0 = manual
//   duty_wr      in   write strobe for a manual duty shadow register
//   duty_sel     in   [SEL_W]     target channel (values >= CHANNELS ignored)
//   duty_data    in   [DUTY_W]    manual duty value
//   step_period  in   [STEP_W]    N -> one breathing step every N+1 periods
//   breath_max   in   [DUTY_W]    breathing ceiling
//   pwm_out      out  [CHANNELS]  registered PWM outputs
//   period_tick  out  one-cycle pulse on the last cycle of every PWM period
//
// Register port handshake: duty_wr is a single-cycle strobe with no
// back-pressure. Each cycle it is high, duty_data is captured into the shadow
// register selected by duty_sel at that clock edge; there is no ready signal
// and no acknowledge.
module pwm_breathe_multi #(
  parameter int CHANNELS = 4,
  parameter int DUTY_W   = 8,
  parameter int STEP_W   = 16,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] mode,
  input  logic                duty_wr,
  input  logic [SEL_W-1:0]    duty_sel,
  input  logic [DUTY_W-1:0]   duty_data,
  input  logic [STEP_W-1:0]   step_period,
  input  logic [DUTY_W-1:0]   breath_max,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  // Counter runs 0 .. 2^DUTY_W-2, so a duty of all-ones is high for the
  // whole period and a duty of zero is never high.
  localparam logic [DUTY_W-1:0] CNT_MAX = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [DUTY_W-1:0]   cnt_q, cnt_d;
  logic                wrap;
  logic [DUTY_W-1:0]   shadow_q [CHANNELS];
  logic [DUTY_W-1:0]   shadow_d [CHANNELS];
  logic [DUTY_W-1:0]   active_q [CHANNELS];
  logic [DUTY_W-1:0]   active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  assign wrap        = en && (cnt_q == CNT_MAX);
  assign period_tick = wrap && !rst;
  assign pwm_out     = pwm_q;

  // Shared period counter
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Shadow registers. Comparing against each channel index (rather than
  // indexing by duty_sel) makes out-of-range selects fall through naturally.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (duty_wr && (duty_sel == SEL_W'(i))) begin
        shadow_d[i] = duty_data;
      end
    end
  end

  // Output compare uses the pre-wrap active value, so the first cycle of a
  // new period still reflects the old duty.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en && (cnt_q < active_q[i]);
    end
  end

`ifdef PWM_BREATHE_EN
  logic [STEP_W-1:0]   scnt_q, scnt_d;
  logic                step;
  logic [DUTY_W-1:0]   level_q [CHANNELS];
  logic [DUTY_W-1:0]   level_d [CHANNELS];
  logic [CHANNELS-1:0] down_q, down_d;   // ramp direction, 1 = falling

  assign step = wrap && (scnt_q == step_period);

  always_comb begin
    scnt_d = scnt_q;
    if (wrap) begin
      scnt_d = step ? '0 : scnt_q + 1'b1;
    end
  end

  // Triangle ramp. Each end of the ramp spends one extra step in place while
  // the direction flips, giving the one-step dwell. The ceiling is checked
  // only while rising, so lowering breath_max clamps on the next up step.
  always_comb begin
    down_d = down_q;
    for (int i = 0; i < CHANNELS; i++) begin
      level_d[i] = level_q[i];
      if (!mode[i]) begin
        // Manual channels keep their ramp parked so breathing restarts at 0
        level_d[i] = '0;
        down_d[i]  = 1'b0;
      end else if (step) begin
        if (!down_q[i]) begin
          if (level_q[i] >= breath_max) begin
            level_d[i] = breath_max;
            down_d[i]  = 1'b1;
          end else begin
            level_d[i] = level_q[i] + 1'b1;
          end
        end else begin
          if (level_q[i] == '0) begin
            down_d[i] = 1'b0;
          end else begin
            level_d[i] = level_q[i] - 1'b1;
          end
        end
      end
    end
  end

  // active takes the pre-step level, so a step shows up one period later
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_d[i] = active_q[i];
      if (wrap) begin
        active_d[i] = mode[i] ? level_q[i] : shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q <= '0;
      down_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      scnt_q <= scnt_d;
      down_q <= down_d;
      for (int i = 0; i < CHANNELS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_d[i] = wrap ? shadow_q[i] : active_q[i];
    end
  end

  // Breathing controls are kept on the port list but have no function here
  logic unused_cfg;
  assign unused_cfg = ^{mode, step_period, breath_max};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
module tb_pwm_breathe_multi;

  localparam int CH   = 4;
  localparam int CH6  = 6;
  localparam int MAXC = 254;   // last counter value of a 255-cycle period
`ifdef PWM_BREATHE_EN
  localparam bit BREATHE = 1'b1;
`else
  localparam bit BREATHE = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  mode = '0;
  logic        duty_wr = 1'b0;
  logic [1:0]  duty_sel = '0;
  logic [7:0]  duty_data = '0;
  logic [15:0] step_period = '0;
  logic [7:0]  breath_max = '0;
  logic [3:0]  pwm_out;
  logic        period_tick;

  logic        duty_wr6 = 1'b0;
  logic [2:0]  duty_sel6 = '0;
  logic [7:0]  duty_data6 = '0;
  logic [5:0]  mode6 = '0;
  logic [5:0]  pwm6;
  logic        tick6;

  always #5 clk = ~clk;

  pwm_breathe_multi #(.CHANNELS(CH), .DUTY_W(8), .STEP_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_data(duty_data),
    .step_period(step_period), .breath_max(breath_max),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  pwm_breathe_multi #(.CHANNELS(CH6), .DUTY_W(8), .STEP_W(16)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode6),
    .duty_wr(duty_wr6), .duty_sel(duty_sel6), .duty_data(duty_data6),
    .step_period(step_period), .breath_max(breath_max),
    .pwm_out(pwm6), .period_tick(tick6)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Written directly from the behavioural rules: one period = 255 counts,
  // duties latch at the period boundary, breathing walks a triangle.
  int       m_cnt, m_scnt;
  int       m_shadow [CH];
  int       m_active [CH];
  int       m_level  [CH];
  bit       m_rising [CH];
  logic [3:0] m_pwm;
  bit       m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_scnt = 0; m_pwm = '0; m_valid = 1'b1;
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; m_level[i] = 0; m_rising[i] = 1'b1;
      end
    end else begin
      bit boundary, do_step;
      boundary = en && (m_cnt == MAXC);
      do_step  = 1'b0;
      for (int i = 0; i < CH; i++) m_pwm[i] = en && (m_cnt < m_active[i]);
      if (boundary) begin
        do_step = (m_scnt == int'(step_period));
        m_scnt  = do_step ? 0 : (m_scnt + 1) % 65536;
        for (int i = 0; i < CH; i++)
          m_active[i] = (BREATHE && mode[i]) ? m_level[i] : m_shadow[i];
      end
      if (duty_wr) m_shadow[duty_sel] = duty_data;
      if (BREATHE) begin
        for (int i = 0; i < CH; i++) begin
          if (!mode[i]) begin
            m_level[i] = 0; m_rising[i] = 1'b1;
          end else if (do_step) begin
            if (m_rising[i]) begin
              if (m_level[i] >= int'(breath_max)) begin
                m_level[i] = breath_max; m_rising[i] = 1'b0;
              end else m_level[i] = m_level[i] + 1;
            end else begin
              if (m_level[i] == 0) m_rising[i] = 1'b1;
              else m_level[i] = m_level[i] - 1;
            end
          end
        end
      end
      if (en) m_cnt = (m_cnt == MAXC) ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pwm_out", pwm_out, m_pwm);
      check("model_period_tick", period_tick, (m_cnt == MAXC) && en && !rst);
    end
  end

  // ---------------- period monitor ----------------
  // A sample of pwm_out reflects the previous cycle's counter, so a period
  // closes on the sample after period_tick.
  int acc [8], acc6 [8], last_cnt [8], last_cnt6 [8];
  int len = 0, last_len = 0, n_periods = 0;
  bit tick_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin acc[i] = 0; acc6[i] = 0; end
      len = 0; tick_prev = 1'b0;
    end else begin
      for (int i = 0; i < CH; i++)  acc[i]  += int'(pwm_out[i]);
      for (int i = 0; i < CH6; i++) acc6[i] += int'(pwm6[i]);
      len++;
      if (tick_prev) begin
        for (int i = 0; i < 8; i++) begin
          last_cnt[i] = acc[i]; last_cnt6[i] = acc6[i]; acc[i] = 0; acc6[i] = 0;
        end
        last_len = len; len = 0; n_periods++;
      end
      tick_prev = period_tick;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_duty(input int sel, input int data);
    @(posedge clk); #1;
    duty_wr = 1'b1; duty_sel = 2'(sel); duty_data = 8'(data);
    @(posedge clk); #1 duty_wr = 1'b0;
  endtask

  task automatic write_duty6(input int sel, input int data);
    @(posedge clk); #1;
    duty_wr6 = 1'b1; duty_sel6 = 3'(sel); duty_data6 = 8'(data);
    @(posedge clk); #1 duty_wr6 = 1'b0;
  endtask

  task automatic wait_period();
    int start;
    start = n_periods;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (n_periods != start) return;
    end
    check("wait_period_timeout", 0, 1);
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (period_tick) return;
    end
    check("wait_tick_timeout", 0, 1);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int duty   [4];
    int exp_hi [4];
  } vec_t;
  vec_t vecs [3];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, first_t, second_t, nt;
    int c1, c2, c3;

    vecs[0].duty = '{64, 0, 255, 128}; vecs[0].exp_hi = '{64, 0, 255, 128};
    vecs[1].duty = '{1, 254, 200, 3};  vecs[1].exp_hi = '{1, 254, 200, 3};
    vecs[2].duty = '{255, 255, 0, 100}; vecs[2].exp_hi = '{255, 255, 0, 100};

    // ---- reset / idle ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pwm_out", pwm_out, 0);
    check("reset_period_tick", period_tick, 0);
    en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bad = 0; first_t = 0; second_t = 0; nt = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (pwm_out != 0) bad++;
      if (period_tick) begin
        nt++;
        if (nt == 1) first_t = k;
        if (nt == 2) second_t = k;
      end
    end
    check("idle_pwm_high_samples", bad, 0);
    check("idle_first_tick", first_t, 255);
    check("idle_second_tick", second_t, 510);
    check("idle_tick_count", nt, 2);

    // ---- manual duty table ----
    for (int v = 0; v < 3; v++) begin
      wait_period();
      for (int c = 0; c < CH; c++) write_duty(c, vecs[v].duty[c]);
      wait_period();
      wait_period();
      for (int c = 0; c < CH; c++)
        check($sformatf("manual_v%0d_ch%0d", v, c), last_cnt[c], vecs[v].exp_hi[c]);
    end

    // ---- shadow timing: write in the period_tick cycle ----
    wait_period();
    write_duty(0, 64);
    wait_period();
    wait_period();
    wait_tick();
    duty_wr = 1'b1; duty_sel = 2'd0; duty_data = 8'd200;
    @(posedge clk); #1 duty_wr = 1'b0;
    wait_period(); c1 = last_cnt[0];
    wait_period(); c2 = last_cnt[0];
    wait_period(); c3 = last_cnt[0];
    check("shadow_closing_period", c1, 64);
    check("shadow_deferred_period", c2, 64);
    check("shadow_new_period", c3, 200);

`ifdef PWM_BREATHE_EN
    // ---- breathing triangle ----
    begin
      int exp_b [11];
      exp_b = '{0, 0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
      mode = 4'b0001; step_period = 16'd0; breath_max = 8'd3;
      do_reset(2);
      for (int j = 0; j < 11; j++) begin
        wait_period();
        check($sformatf("breathe_period%0d", j), last_cnt[0], exp_b[j]);
      end
      check("breathe_manual_ch3", last_cnt[3], 0);
    end

    // ---- ceiling clamp while rising ----
    begin
      int exp_c [4];
      exp_c = '{9, 10, 5, 4};
      breath_max = 8'd20;
      do_reset(2);
      for (int j = 0; j < 10; j++) wait_period();
      breath_max = 8'd5;
      for (int j = 0; j < 4; j++) begin
        wait_period();
        check($sformatf("clamp_period%0d", j), last_cnt[0], exp_c[j]);
      end
    end
`endif

    // ---- reset mid-period ----
    begin
      int exp_r [3];
      exp_r = BREATHE ? '{0, 0, 1} : '{0, 0, 0};
      write_duty(1, 255);
      wait_period();
      wait_period();
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("abort_pre_ch1_high", pwm_out[1], 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_pwm_out", pwm_out, 0);
      check("abort_period_tick", period_tick, 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
        wait_period();
        check($sformatf("abort_restart_ch0_p%0d", j), last_cnt[0], exp_r[j]);
        check($sformatf("abort_ch1_cleared_p%0d", j), last_cnt[1], 0);
      end
    end

    // ---- en gating ----
    mode = 4'b0000;
    wait_period();
    write_duty(0, 100);
    wait_period();
    wait_period();
    repeat (50) @(posedge clk);
    #1 en = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k > 0 && (pwm_out != 0 || period_tick)) bad++;
      @(posedge clk);
    end
    #1 en = 1'b1;
    check("en_off_outputs", bad, 0);
    wait_period();
    check("en_resume_high_count", last_cnt[0], 100);
    check("en_resume_period_len", last_len, 305);

    // ---- select range on a 6-channel build ----
    wait_period();
    write_duty6(5, 77);
    write_duty6(7, 200);
    write_duty6(6, 33);
    wait_period();
    wait_period();
    check("sel6_ch5_written", last_cnt6[5], 77);
    for (int c = 0; c < 5; c++)
      check($sformatf("sel6_ch%0d_untouched", c), last_cnt6[c], 0);

    // ---- randomized run against the model ----
    do_reset(2);
    for (int seg = 0; seg < 30; seg++) begin
      int seg_len;
      mode        = 4'($urandom);
      step_period = 16'($urandom_range(0, 3));
      breath_max  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 6));
      seg_len = $urandom_range(300, 900);
      for (int c = 0; c < seg_len; c++) begin
        int pick;
        @(posedge clk); #1;
        duty_wr  = ($urandom_range(0, 7) == 0);
        duty_sel = 2'($urandom);
        pick = $urandom_range(0, 4);
        case (pick)
          0: duty_data = 8'd0;
          1: duty_data = 8'd1;
          2: duty_data = 8'd254;
          3: duty_data = 8'd255;
          default: duty_data = 8'($urandom);
        endcase
        en  = ($urandom_range(0, 29) != 0);
        rst = ($urandom_range(0, 999) == 0);
      end
    end
    @(posedge clk); #1;
    duty_wr = 1'b0; rst = 1'b0; en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
